// File: rtl/mc_controller_if.sv
// Handshake bundle between the multicycle controller and its datapath.
// The controller takes the slave view; the datapath side drives the instruction fields.
interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output op, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state
  );

  modport slave (
    input  op, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state
  );
endinterface

// File: rtl/mc_controller.sv
// Moore FSM controller for a multicycle RISC-V subset (lw/sw/R/I/beq/bne/jal).
// Define MCU_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE until mem_ready.
module mc_controller (
  input  logic           clk,
  input  logic           reset_n,
  mc_controller_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     r_state;
  state_t     w_next;
  logic       r_irWrite;
  logic       r_pcUpdate;
  logic       r_adrSrc;
  logic       r_memWrite;
  logic       r_regWrite;
  logic       r_branch;
  logic [1:0] r_resultSrc;
  logic [1:0] r_aluSrcA;
  logic [1:0] r_aluSrcB;
  logic [1:0] r_aluOp;
  logic       w_memReady;
  logic       w_fetchStall;
  logic       w_opLegal;

`ifdef MCU_MEM_WAIT_EN
  assign w_memReady = bus.mem_ready;
`else
  logic w_unusedMemReady;
  assign w_unusedMemReady = bus.mem_ready;
  assign w_memReady       = 1'b1;
`endif

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = w_memReady ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = EXECR;
          OP_I:         w_next = EXECI;
          OP_B:         w_next = BRANCH;
          OP_JAL:       w_next = JAL;
          default:      w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = bus.op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  w_next = w_memReady ? MEMWB : MEMREAD;
      MEMWRITE: w_next = w_memReady ? FETCH : MEMWRITE;
      EXECR:    w_next = ALUWB;
      EXECI:    w_next = ALUWB;
      JAL:      w_next = ALUWB;
      default:  w_next = FETCH;
    endcase
  end

  // Control outputs are registered for the state being entered, so they line up with r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= FETCH;
      r_irWrite   <= 1'b1;
      r_pcUpdate  <= 1'b1;
      r_adrSrc    <= 1'b0;
      r_memWrite  <= 1'b0;
      r_regWrite  <= 1'b0;
      r_branch    <= 1'b0;
      r_resultSrc <= 2'b10;
      r_aluSrcA   <= 2'b00;
      r_aluSrcB   <= 2'b10;
      r_aluOp     <= 2'b00;
    end else begin
      r_state     <= w_next;
      r_irWrite   <= 1'b0;
      r_pcUpdate  <= 1'b0;
      r_adrSrc    <= 1'b0;
      r_memWrite  <= 1'b0;
      r_regWrite  <= 1'b0;
      r_branch    <= 1'b0;
      r_resultSrc <= 2'b00;
      r_aluSrcA   <= 2'b00;
      r_aluSrcB   <= 2'b00;
      r_aluOp     <= 2'b00;
      case (w_next)
        FETCH: begin
          r_irWrite   <= 1'b1;
          r_pcUpdate  <= 1'b1;
          r_aluSrcB   <= 2'b10;
          r_resultSrc <= 2'b10;
        end
        DECODE: begin
          r_aluSrcA <= 2'b01;
          r_aluSrcB <= 2'b01;
        end
        MEMADR: begin
          r_aluSrcA <= 2'b10;
          r_aluSrcB <= 2'b01;
        end
        MEMREAD:  r_adrSrc <= 1'b1;
        MEMWB: begin
          r_resultSrc <= 2'b01;
          r_regWrite  <= 1'b1;
        end
        MEMWRITE: begin
          r_adrSrc   <= 1'b1;
          r_memWrite <= 1'b1;
        end
        EXECR: begin
          r_aluSrcA <= 2'b10;
          r_aluOp   <= 2'b10;
        end
        EXECI: begin
          r_aluSrcA <= 2'b10;
          r_aluSrcB <= 2'b01;
          r_aluOp   <= 2'b10;
        end
        ALUWB:    r_regWrite <= 1'b1;
        BRANCH: begin
          r_aluSrcA <= 2'b10;
          r_aluOp   <= 2'b01;
          r_branch  <= 1'b1;
        end
        JAL: begin
          r_aluSrcA  <= 2'b01;
          r_aluSrcB  <= 2'b10;
          r_pcUpdate <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A stalled fetch must not latch the instruction or bump the PC until memory answers.
  assign w_fetchStall = (r_state == FETCH) && !w_memReady;
  assign w_opLegal    = bus.op inside {OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL};

  assign bus.IRWrite   = r_irWrite & ~w_fetchStall;
  assign bus.PCWrite   = (r_branch & (bus.Zero ^ bus.funct3[0])) | (r_pcUpdate & ~w_fetchStall);
  assign bus.AdrSrc    = r_adrSrc;
  assign bus.MemWrite  = r_memWrite;
  assign bus.RegWrite  = r_regWrite;
  assign bus.ResultSrc = r_resultSrc;
  assign bus.ALUSrcA   = r_aluSrcA;
  assign bus.ALUSrcB   = r_aluSrcB;
  assign bus.illegal   = (r_state == DECODE) && !w_opLegal;
  assign bus.state     = r_state;

  always_comb begin
    bus.ImmSrc = 2'b00;
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_B:    bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  // Only R-type (op[5]=1) honours funct7b5 as subtract; addi ignores it.
  always_comb begin
    bus.ALUControl = 4'b0000;
    case (r_aluOp)
      2'b01: bus.ALUControl = 4'b0001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.ALUControl = (bus.op[5] && bus.funct7b5) ? 4'b0001 : 4'b0000;
          3'b010:  bus.ALUControl = 4'b0101;
          3'b100:  bus.ALUControl = 4'b0100;
          3'b110:  bus.ALUControl = 4'b0011;
          3'b111:  bus.ALUControl = 4'b0010;
          default: bus.ALUControl = 4'b0000;
        endcase
      end
      default: bus.ALUControl = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instructions, random instruction mix,
// and an asynchronous reset in MEMREAD, compared against a per-instruction reference model.
module tb_mc_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [3:0] state;
    logic       pcWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] immSrc;
    logic [3:0] aluControl;
    logic       illegal;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   expPath[$];

  always #5 clk = ~clk;

  mc_controller_if bus();

  mc_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic isLegal(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_B)  || (op == OP_JAL);
  endfunction

  // Expected state walk of one instruction, starting at FETCH.
  task automatic buildPath(input logic [6:0] op);
    case (op)
      OP_LW:   expPath = '{0, 1, 2, 3, 4};
      OP_SW:   expPath = '{0, 1, 2, 5};
      OP_R:    expPath = '{0, 1, 6, 8};
      OP_I:    expPath = '{0, 1, 7, 8};
      OP_B:    expPath = '{0, 1, 9};
      OP_JAL:  expPath = '{0, 1, 10, 8};
      default: expPath = '{0, 1};
    endcase
  endtask

  function automatic logic stallNow(input int s, input logic mr);
`ifdef MCU_MEM_WAIT_EN
    return ((s == 0) || (s == 3) || (s == 5)) && !mr;
`else
    return 1'b0;
`endif
  endfunction

  function automatic ctrl_t modelOutputs(input int s, input logic [6:0] op, input logic [2:0] f3,
                                         input logic f7, input logic z, input logic mr);
    ctrl_t      e     = '0;
    logic [1:0] aluOp = 2'b00;
    e.state = s[3:0];
    case (s)
      0: begin
        e.irWrite   = stallNow(0, mr) ? 1'b0 : 1'b1;
        e.pcWrite   = e.irWrite;
        e.aluSrcB   = 2'b10;
        e.resultSrc = 2'b10;
      end
      1: begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b01; end
      2: begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; end
      3: e.adrSrc = 1'b1;
      4: begin e.resultSrc = 2'b01; e.regWrite = 1'b1; end
      5: begin e.adrSrc = 1'b1; e.memWrite = 1'b1; end
      6: begin e.aluSrcA = 2'b10; aluOp = 2'b10; end
      7: begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; aluOp = 2'b10; end
      8: e.regWrite = 1'b1;
      9: begin e.aluSrcA = 2'b10; aluOp = 2'b01; e.pcWrite = z ^ f3[0]; end
      10: begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.pcWrite = 1'b1; end
      default: ;
    endcase
    e.immSrc = (op == OP_SW) ? 2'b01 : (op == OP_B) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
    if (aluOp == 2'b01) e.aluControl = 4'd1;
    else if (aluOp == 2'b10) begin
      case (f3)
        3'b000:  e.aluControl = (op[5] && f7) ? 4'd1 : 4'd0;
        3'b010:  e.aluControl = 4'd5;
        3'b100:  e.aluControl = 4'd4;
        3'b110:  e.aluControl = 4'd3;
        3'b111:  e.aluControl = 4'd2;
        default: e.aluControl = 4'd0;
      endcase
    end
    e.illegal = (s == 1) && !isLegal(op);
    return e;
  endfunction

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic z, input logic mr);
    bus.op        = op;
    bus.funct3    = f3;
    bus.funct7b5  = f7;
    bus.Zero      = z;
    bus.mem_ready = mr;
  endtask

  task automatic checkField(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input int s, input string ctx);
    ctrl_t e;
    e = modelOutputs(s, bus.op, bus.funct3, bus.funct7b5, bus.Zero, bus.mem_ready);
    checkField({ctx, ".state"},      bus.state,            e.state);
    checkField({ctx, ".PCWrite"},    {3'b0, bus.PCWrite},  {3'b0, e.pcWrite});
    checkField({ctx, ".AdrSrc"},     {3'b0, bus.AdrSrc},   {3'b0, e.adrSrc});
    checkField({ctx, ".MemWrite"},   {3'b0, bus.MemWrite}, {3'b0, e.memWrite});
    checkField({ctx, ".IRWrite"},    {3'b0, bus.IRWrite},  {3'b0, e.irWrite});
    checkField({ctx, ".RegWrite"},   {3'b0, bus.RegWrite}, {3'b0, e.regWrite});
    checkField({ctx, ".ResultSrc"},  {2'b0, bus.ResultSrc}, {2'b0, e.resultSrc});
    checkField({ctx, ".ALUSrcA"},    {2'b0, bus.ALUSrcA},  {2'b0, e.aluSrcA});
    checkField({ctx, ".ALUSrcB"},    {2'b0, bus.ALUSrcB},  {2'b0, e.aluSrcB});
    checkField({ctx, ".ImmSrc"},     {2'b0, bus.ImmSrc},   {2'b0, e.immSrc});
    checkField({ctx, ".ALUControl"}, bus.ALUControl,       e.aluControl);
    checkField({ctx, ".illegal"},    {3'b0, bus.illegal},  {3'b0, e.illegal});
  endtask

  // Entered just after a negedge with the DUT in FETCH; leaves at the negedge after the last state.
  task automatic runInstruction(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic z, input int stallPct, input int memWriteStalls,
                                input string name);
    int   idx  = 0;
    int   left = memWriteStalls;
    logic mr;
    buildPath(op);
    while (idx < expPath.size()) begin
      if ((expPath[idx] == 5) && (left > 0)) begin
        mr = 1'b0;
        left--;
      end else begin
        mr = ($urandom_range(0, 99) >= stallPct);
      end
      applyStimulus(op, f3, f7, z, mr);
      #1;
      checkOutput(expPath[idx], name);
      if (!stallNow(expPath[idx], mr)) idx++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [6:0] rop;
    reset_n = 1'b0;
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput(0, "reset");
    reset_n = 1'b1;

    runInstruction(OP_LW,  3'b010, 1'b0, 1'b0, 0, 0, "lw");
    runInstruction(OP_B,   3'b000, 1'b0, 1'b1, 0, 0, "beq");
    runInstruction(OP_B,   3'b001, 1'b0, 1'b1, 0, 0, "bne");
    runInstruction(OP_R,   3'b000, 1'b1, 1'b0, 0, 0, "sub");
    runInstruction(OP_I,   3'b000, 1'b1, 1'b0, 0, 0, "addi");
    runInstruction(7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0, "ecall");
    runInstruction(OP_SW,  3'b010, 1'b0, 1'b0, 0, 3, "swStall");
    runInstruction(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, "jal");

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0: rop = OP_LW;
        1: rop = OP_SW;
        2: rop = OP_R;
        3: rop = OP_I;
        4: rop = OP_B;
        5: rop = OP_JAL;
        default: begin
          rop = 7'($urandom);
          while (isLegal(rop)) rop = 7'($urandom);
        end
      endcase
      runInstruction(rop, 3'($urandom), 1'($urandom), 1'($urandom), 25, 0,
                     $sformatf("rand%0d", n));
    end

    buildPath(OP_LW);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
      #1;
      checkOutput(expPath[k], "preRst");
      @(negedge clk);
    end
    #1;
    checkOutput(3, "inMemRead");
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput(0, "asyncRst");
    @(negedge clk);
    reset_n = 1'b1;
    runInstruction(OP_R, 3'b111, 1'b0, 1'b0, 0, 0, "afterRst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
